// File: rtl/limn2600_cache_pkg.sv
// Shared types and width helpers for the Limn2600 cache controller.
package limn2600_cache_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [2:0] {
        FLUSH  = 3'd0,
        IDLE   = 3'd1,
        LOOKUP = 3'd2,
        MEM    = 3'd3,
        FILL   = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Index bits for a cache of n lines (n is a power of two).
    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n);
    endfunction

    // Tag bits left after removing the byte offset and the index.
    function automatic int unsigned tag_width(input int unsigned n);
        return ADDR_W - 2 - $clog2(n);
    endfunction

endpackage

// File: rtl/limn2600_cache_store.sv
// Valid/tag/data arrays: one combinational read port, one synchronous write
// port and a per-index valid clear used by the flush sweep.
module limn2600_cache_store
    import limn2600_cache_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4096,
    parameter int unsigned DATA_WIDTH  = 32,
    localparam int unsigned IDX_W      = idx_width(NUM_ENTRIES),
    localparam int unsigned TAG_W      = tag_width(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic                  wr_data_only,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_en,
    input  logic [IDX_W-1:0]      clr_idx
);

    logic                  valid_q [NUM_ENTRIES];
    logic [TAG_W-1:0]      tag_q   [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] data_q  [NUM_ENTRIES];

    // Combinational lookup of the addressed line.
    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_data  = data_q[rd_idx];
    end

    // Line updates: write-hit patches data only, refill installs the whole line.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end
        if (wr_en && !wr_data_only) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
        end
        if (wr_en) begin
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/limn2600_cache_ctrl.sv
// Limn2600 direct-mapped cache controller: round-robin fetch/data arbitration,
// read refill on miss, write-through without allocate, full-cache flush.
module limn2600_cache_ctrl
    import limn2600_cache_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 4096,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [31:0]           i_addr,
    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_port,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  flush_req,
    output logic                  busy,
    output logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned IDX_W  = idx_width(NUM_ENTRIES);
    localparam int unsigned TAG_W  = tag_width(NUM_ENTRIES);
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    state_t                state_q;
    state_t                state_nxt;
    logic [IDX_W-1:0]      cnt_q;
    logic                  pending_q;
    logic                  last_q;
    logic [WORD_W-1:0]     req_word_q;
    logic                  req_we_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic                  req_port_q;
    logic                  req_hit_q;
    logic [DATA_WIDTH-1:0] line_q;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic                  wr_data_only;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic                  hit_c;
    logic                  unused_addr_bits;

    assign req_idx = req_word_q[IDX_W-1:0];
    assign req_tag = req_word_q[WORD_W-1:IDX_W];
    assign hit_c   = rd_valid && (rd_tag == req_tag);

    // Byte-offset bits never reach the cache or memory.
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    limn2600_cache_store #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_store (
        .clk          (clk),
        .rd_idx       (req_idx),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        (wr_en),
        .wr_data_only (wr_data_only),
        .wr_idx       (req_idx),
        .wr_tag       (req_tag),
        .wr_data      (wr_data),
        .clr_en       (state_q == FLUSH),
        .clr_idx      (cnt_q)
    );

    // State register; reset aborts any transaction and restarts the flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FLUSH;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state, arbitration grant and store write controls.
    always_comb begin
        state_nxt    = state_q;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        wr_en        = 1'b0;
        wr_data_only = 1'b0;
        wr_data      = line_q;
        case (state_q)
            FLUSH: begin
                if (!flush_req && cnt_q == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_nxt = FLUSH;
                end else if (i_valid && (!d_valid || last_q == PORT_D)) begin
                    i_ready   = 1'b1;
                    state_nxt = LOOKUP;
                end else if (d_valid) begin
                    d_ready   = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                state_nxt = (hit_c && !req_we_q) ? RESP : MEM;
            end
            MEM: begin
                if (mem_ack) begin
                    state_nxt = req_we_q ? RESP : FILL;
                    if (req_we_q && req_hit_q) begin
                        wr_en        = 1'b1;
                        wr_data_only = 1'b1;
                        wr_data      = req_wdata_q;
                    end
                end
            end
            FILL: begin
                wr_en     = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                state_nxt = (pending_q || flush_req) ? FLUSH : IDLE;
            end
            default: begin
                state_nxt = FLUSH;
            end
        endcase
    end

    // Flush counter, pending flush, grant pointer, request latch and line data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            pending_q   <= 1'b0;
            last_q      <= PORT_D;
            req_word_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            req_port_q  <= PORT_I;
            req_hit_q   <= 1'b0;
            line_q      <= '0;
        end else begin
            if (state_q == FLUSH) begin
                cnt_q <= (flush_req || cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_W'(1);
            end

            if (state_q == RESP) begin
                pending_q <= 1'b0;
            end else if (flush_req && state_q != IDLE && state_q != FLUSH) begin
                pending_q <= 1'b1;
            end

            if (i_ready || d_ready) begin
                req_port_q  <= d_ready;
                last_q      <= d_ready ? PORT_D : PORT_I;
                req_word_q  <= d_ready ? d_addr[31:2] : i_addr[31:2];
                req_we_q    <= d_ready && d_we;
                req_wdata_q <= d_ready ? d_wdata : '0;
            end

            if (state_q == LOOKUP) begin
                req_hit_q <= hit_c;
                if (hit_c && !req_we_q) begin
                    line_q <= rd_data;
                end
            end

            if (state_q == MEM && mem_ack) begin
                line_q <= req_we_q ? '0 : mem_rdata;
            end
        end
    end

    // Outputs decoded from the registered state and request latch.
    assign busy      = (state_q != IDLE);
    assign mem_req   = (state_q == MEM);
    assign mem_we    = (state_q == MEM) && req_we_q;
    assign mem_addr  = {req_word_q, 2'b00};
    assign mem_wdata = req_wdata_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_port  = req_port_q;
    assign rsp_data  = (state_q == RESP) ? line_q : '0;

endmodule

// File: tb/tb_limn2600_cache_ctrl.sv
// Directed bench for limn2600_cache_ctrl with a 16-line cache.
module tb_limn2600_cache_ctrl;

    localparam int unsigned N  = 16;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_ready;
    logic [31:0]   i_addr;
    logic          d_valid, d_ready, d_we;
    logic [31:0]   d_addr;
    logic [DW-1:0] d_wdata;
    logic          rsp_valid, rsp_port;
    logic [DW-1:0] rsp_data;
    logic          flush_req, busy;
    logic          mem_req, mem_ack, mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    limn2600_cache_ctrl #(.NUM_ENTRIES(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
        .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_data(rsp_data),
        .flush_req(flush_req), .busy(busy),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        to_mem;
        int          ack_dly;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        flush_mem;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic port, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic to_mem, input int ack_dly,
                                input logic [31:0] rdata, input logic [31:0] exp_data,
                                input logic flush_mem);
        vec_t v;
        v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.to_mem = to_mem;
        v.ack_dly = ack_dly; v.rdata = rdata; v.exp_data = exp_data; v.flush_mem = flush_mem;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called in the first flush cycle; expects 16 busy cycles then IDLE.
    task automatic wait_flush(input string tag);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (busy !== 1'b1 || i_ready !== 1'b0 || d_ready !== 1'b0) ok = 1'b0;
            @(negedge clk); #1;
        end
        check({tag, " flush busy"}, 32'(ok), 32'd1);
        check({tag, " idle after flush"}, 32'(busy), 32'd0);
    endtask

    // One request through the whole handshake/memory/response sequence.
    task automatic run_req(input vec_t v, input string tag);
        int   w;
        logic rdy;
        @(negedge clk);
        if (v.port) begin
            d_valid = 1'b1; d_addr = v.addr; d_we = v.we; d_wdata = v.wdata;
        end else begin
            i_valid = 1'b1; i_addr = v.addr;
        end
        #1;
        w = 0;
        rdy = v.port ? d_ready : i_ready;
        while (!rdy && w < 50) begin
            @(negedge clk); #1;
            rdy = v.port ? d_ready : i_ready;
            w++;
        end
        check({tag, " grant"}, 32'(rdy), 32'd1);
        @(negedge clk); #1;
        i_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0;
        if (!rdy) return;
        @(negedge clk); #1;
        if (!v.to_mem) begin
            check({tag, " hit rsp_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " hit no mem_req"}, 32'(mem_req), 32'd0);
        end else begin
            check({tag, " mem_req"}, 32'(mem_req), 32'd1);
            check({tag, " early rsp"}, 32'(rsp_valid), 32'd0);
            check({tag, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
            check({tag, " mem_we"}, 32'(mem_we), 32'(v.we));
            if (v.we) check({tag, " mem_wdata"}, mem_wdata, v.wdata);
            for (int d = 0; d < v.ack_dly; d++) begin
                if (d == 0 && v.flush_mem) flush_req = 1'b1;
                @(negedge clk); #1;
                flush_req = 1'b0;
                check({tag, " mem_req held"}, 32'(mem_req), 32'd1);
            end
            mem_ack = 1'b1; mem_rdata = v.rdata;
            @(negedge clk); #1;
            mem_ack = 1'b0; mem_rdata = '0;
            if (!v.we) begin
                check({tag, " fill no rsp"}, 32'(rsp_valid), 32'd0);
                @(negedge clk); #1;
            end
            check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        end
        check({tag, " rsp_port"}, 32'(rsp_port), 32'(v.port));
        check({tag, " rsp_data"}, rsp_data, v.exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic        gport [4];
        logic        rport [4];
        logic [31:0] rdat  [4];
        int          ng, nr, w;

        // port, we, addr, wdata, to_mem, ack_dly, rdata, exp_data, flush_mem
        vecs[0]  = mk(1, 0, 32'h100, 32'h0,        1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        vecs[1]  = mk(1, 0, 32'h100, 32'h0,        0, 0, 32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 0, 32'h140, 32'h0,        1, 1, 32'hCAFEF00D, 32'hCAFEF00D, 0);
        vecs[3]  = mk(1, 0, 32'h100, 32'h0,        1, 2, 32'hDEADBEEF, 32'hDEADBEEF, 0);
        vecs[4]  = mk(1, 1, 32'h100, 32'h12345678, 1, 1, 32'h0,        32'h0,        0);
        vecs[5]  = mk(1, 0, 32'h100, 32'h0,        0, 0, 32'h0,        32'h12345678, 0);
        vecs[6]  = mk(1, 1, 32'h200, 32'h55AA55AA, 1, 2, 32'h0,        32'h0,        0);
        vecs[7]  = mk(1, 0, 32'h200, 32'h0,        1, 0, 32'h55AA55AA, 32'h55AA55AA, 0);
        vecs[8]  = mk(0, 0, 32'h104, 32'h0,        1, 1, 32'h0BADF00D, 32'h0BADF00D, 0);
        vecs[9]  = mk(0, 0, 32'h104, 32'h0,        0, 0, 32'h0,        32'h0BADF00D, 0);
        vecs[10] = mk(1, 0, 32'h104, 32'h0,        0, 0, 32'h0,        32'h0BADF00D, 0);
        vecs[11] = mk(0, 0, 32'h200, 32'h0,        0, 0, 32'h0,        32'h55AA55AA, 0);
        vecs[12] = mk(1, 1, 32'h104, 32'h11112222, 1, 0, 32'h0,        32'h0,        0);
        vecs[13] = mk(0, 0, 32'h106, 32'h0,        0, 0, 32'h0,        32'h11112222, 0);

        rst = 1'b0;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_we = 1'b0; d_wdata = '0;
        flush_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst i_ready",   32'(i_ready),   32'd0);
        check("rst d_ready",   32'(d_ready),   32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_port",  32'(rsp_port),  32'd0);
        check("rst rsp_data",  rsp_data,       32'd0);
        check("rst mem_req",   32'(mem_req),   32'd0);
        check("rst mem_we",    32'(mem_we),    32'd0);
        check("rst mem_addr",  mem_addr,       32'd0);
        check("rst mem_wdata", mem_wdata,      32'd0);
        check("rst busy",      32'(busy),      32'd1);

        // Flush after release; fetch held valid must not be granted until IDLE
        i_valid = 1'b1; i_addr = 32'h300;
        @(negedge clk);
        rst = 1'b1;
        #1;
        wait_flush("reset");
        check("i_ready follows i_valid", 32'(i_ready), 32'd1);
        i_valid = 1'b0;
        #1;
        check("i_ready drops", 32'(i_ready), 32'd0);

        foreach (vecs[k]) run_req(vecs[k], $sformatf("vec%0d", k));

        // Flush request in IDLE beats a valid data request
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h104; flush_req = 1'b1;
        #1;
        check("idle flush blocks ready", 32'(d_ready), 32'd0);
        @(negedge clk);
        flush_req = 1'b0; d_valid = 1'b0;
        #1;
        wait_flush("idle flush");
        run_req(mk(1, 0, 32'h104, 32'h0, 1, 1, 32'h0BADF00D, 32'h0BADF00D, 0), "after idle flush");

        // Flush request during MEM is served after RESP
        run_req(mk(1, 0, 32'h108, 32'h0, 1, 2, 32'hA0A0A0A0, 32'hA0A0A0A0, 1), "flush in mem");
        @(negedge clk); #1;
        wait_flush("pending flush");
        run_req(mk(1, 0, 32'h108, 32'h0, 1, 1, 32'hB0B0B0B0, 32'hB0B0B0B0, 0), "after pending flush");

        // Round-robin with both ports held valid and immediate acks
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b1; i_addr = 32'h400;
        d_valid = 1'b1; d_addr = 32'h800; d_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        wait_flush("arb reset");
        ng = 0; nr = 0;
        for (int c = 0; c < 200 && nr < 4; c++) begin
            if (ng >= 4) begin i_valid = 1'b0; d_valid = 1'b0; end
            mem_ack = mem_req;
            mem_rdata = mem_addr ^ 32'h5A5A0000;
            if (ng < 4 && i_valid && i_ready) begin gport[ng] = 1'b0; ng++; end
            else if (ng < 4 && d_valid && d_ready) begin gport[ng] = 1'b1; ng++; end
            if (rsp_valid) begin rport[nr] = rsp_port; rdat[nr] = rsp_data; nr++; end
            @(negedge clk); #1;
        end
        mem_ack = 1'b0; mem_rdata = '0;
        i_valid = 1'b0; d_valid = 1'b0;
        check("arb responses", 32'(nr), 32'd4);
        if (nr == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("arb grant%0d", k), 32'(gport[k]), 32'(k % 2));
                check($sformatf("arb rsp_port%0d", k), 32'(rport[k]), 32'(k % 2));
                check($sformatf("arb rsp_data%0d", k), rdat[k], (k % 2) ? 32'h5A5A0800 : 32'h5A5A0400);
            end
        end

        // Reset in the middle of a miss
        @(negedge clk);
        d_valid = 1'b1; d_addr = 32'h900; d_we = 1'b0;
        #1;
        w = 0;
        while (!d_ready && w < 50) begin @(negedge clk); #1; w++; end
        check("midrst grant", 32'(d_ready), 32'd1);
        @(negedge clk); #1;
        d_valid = 1'b0;
        @(negedge clk); #1;
        check("midrst mem_req up", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst mem_req drop", 32'(mem_req), 32'd0);
        check("midrst mem_addr", mem_addr, 32'd0);
        check("midrst busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        wait_flush("midrst");
        run_req(mk(1, 0, 32'h400, 32'h0, 1, 1, 32'h77770400, 32'h77770400, 0), "after midrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
